// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and helpers for the Shift4 sequencer.
package shift_seq_ctrl_pkg;

    localparam int DEFAULT_SIZE = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Requested length of 0 or anything wider than the register means "all bits".
    function automatic int eff_len(input int len, input int sz);
        return ((len == 0) || (len > sz)) ? sz : len;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the Shift4 parallel-load / right-shift register.
// Takes words on a valid/ready handshake, loads them into Shift4 and
// streams q[0] out LSB-first on its own valid/ready interface.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no word in flight, ready to accept a new one
// ST_SHIFT | word loaded, cnt bits (including the current one) remain
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int  size  = DEFAULT_SIZE,
    localparam int LEN_W = $clog2(size + 1)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [size-1:0]  in_data,
    input  logic [LEN_W-1:0] in_len,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             sr_areset,
    output logic             sr_load,
    output logic             sr_ena,
    output logic [size-1:0]  sr_data,
    input  logic [size-1:0]  sr_q
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic [LEN_W-1:0] len_eff;
    logic             cnt_last;
    logic             accept;
    logic             xfer;
    logic             unused_sr_q;

    assign len_eff  = LEN_W'(eff_len(int'(in_len), size));
    assign cnt_last = (cnt == LEN_W'(1));

    // Only q[0] is observed; upper bits leave the register without being looked at.
    assign unused_sr_q = ^sr_q[size-1:1];

    assign ser_bit   = sr_q[0];
    assign sr_data   = in_data;
    assign sr_areset = ~areset_n;

    // State and bit counter register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: count bits down, reload on back-to-back words, else drop to idle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = len_eff;
                end
            end
            ST_SHIFT: begin
                if (xfer) begin
                    if (!cnt_last) begin
                        cnt_nxt = cnt - LEN_W'(1);
                    end else if (accept) begin
                        cnt_nxt = len_eff;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Handshake and Shift4 controls; all held inactive while reset is asserted.
    // ser_valid depends on state only, so ser_ready never reaches it combinationally.
    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        sr_load   = 1'b0;
        sr_ena    = 1'b0;
        accept    = 1'b0;
        xfer      = 1'b0;
        if (areset_n) begin
            ser_valid = (state == ST_SHIFT);
            xfer      = ser_valid & ser_ready;
            in_ready  = (state == ST_IDLE) | (xfer & cnt_last);
            accept    = in_valid & in_ready;
            ser_last  = ser_valid & cnt_last;
            sr_load   = accept;
            // A reload on the last bit takes priority over the shift.
            sr_ena    = xfer & ~sr_load;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural Shift4 register attached.
module tb_shift_seq_ctrl;

    logic       clk;
    logic       areset_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [2:0] in_len;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_bit;
    logic       ser_last;
    logic       sr_areset;
    logic       sr_load;
    logic       sr_ena;
    logic [3:0] sr_data;
    logic [3:0] sr_q;

    int checks   = 0;
    int failures = 0;

    shift_seq_ctrl #(.size(4)) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_bit   (ser_bit),
        .ser_last  (ser_last),
        .sr_areset (sr_areset),
        .sr_load   (sr_load),
        .sr_ena    (sr_ena),
        .sr_data   (sr_data),
        .sr_q      (sr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift4 model: async reset, load wins over ena, right shift fills with 0.
    always @(posedge clk or posedge sr_areset) begin
        if (sr_areset)    sr_q <= 4'b0000;
        else if (sr_load) sr_q <= sr_data;
        else if (sr_ena)  sr_q <= {1'b0, sr_q[3:1]};
    end

    task automatic test_reset();
        @(negedge clk);
        areset_n = 1'b0; in_valid = 1'b1; in_data = 4'b1011; in_len = 3'd4; ser_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({in_ready, ser_valid, ser_last, sr_areset, sr_load, sr_ena} !== 6'b000100) begin
            failures++;
            $display("FAIL reset_outputs got rdy/vld/last/arst/load/ena=%b exp=000100",
                     {in_ready, ser_valid, ser_last, sr_areset, sr_load, sr_ena});
        end
        @(negedge clk);
        areset_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++;
        if ({in_ready, ser_valid, sr_areset} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release_idle got rdy/vld/arst=%b exp=100", {in_ready, ser_valid, sr_areset});
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b1011; in_len = 3'd4; ser_ready = 1'b1;
        #1;
        checks++;
        if ({in_ready, sr_load, ser_valid} !== 3'b110) begin
            failures++;
            $display("FAIL single_accept got rdy/load/vld=%b exp=110", {in_ready, sr_load, ser_valid});
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({ser_valid, ser_bit, ser_last} !== {1'b1, exp_bits[i], 1'(i == 3)}) begin
                failures++;
                $display("FAIL single_bit%0d got vld/bit/last=%b exp=%b", i,
                         {ser_valid, ser_bit, ser_last}, {1'b1, exp_bits[i], 1'(i == 3)});
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({ser_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL single_idle got vld/rdy=%b exp=01", {ser_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bits;
        exp_bits = 8'b1110_0001;
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0001; in_len = 3'd4; ser_ready = 1'b1;
        #1;
        checks++;
        if (sr_load !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_load got=%b exp=1", sr_load);
        end
        @(negedge clk);
        in_data = 4'b1110;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) in_valid = 1'b0;
            #1;
            checks++;
            if ({ser_valid, ser_bit, ser_last, in_ready, sr_load, sr_ena} !==
                {1'b1, exp_bits[i], 1'(i == 3 || i == 7), 1'(i == 3 || i == 7), 1'(i == 3), 1'(i != 3)}) begin
                failures++;
                $display("FAIL b2b_bit%0d got vld/bit/last/rdy/load/ena=%b exp=%b", i,
                         {ser_valid, ser_bit, ser_last, in_ready, sr_load, sr_ena},
                         {1'b1, exp_bits[i], 1'(i == 3 || i == 7), 1'(i == 3 || i == 7), 1'(i == 3), 1'(i != 3)});
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({ser_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_idle got vld/rdy=%b exp=01", {ser_valid, in_ready});
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_bit, exp_last, exp_ena, exp_rdy;
        exp_bit  = 4'b1100;
        exp_last = 4'b1100;
        exp_ena  = 4'b1010;
        exp_rdy  = 4'b1000;
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0110; in_len = 3'd2; ser_ready = 1'b0;
        #1;
        checks++;
        if (sr_load !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept got load=%b exp=1", sr_load);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ser_ready = 1'(k % 2);
            #1;
            checks++;
            if ({ser_valid, ser_bit, ser_last, sr_ena, in_ready} !==
                {1'b1, exp_bit[k], exp_last[k], exp_ena[k], exp_rdy[k]}) begin
                failures++;
                $display("FAIL bp_cycle%0d got vld/bit/last/ena/rdy=%b exp=%b", k,
                         {ser_valid, ser_bit, ser_last, sr_ena, in_ready},
                         {1'b1, exp_bit[k], exp_last[k], exp_ena[k], exp_rdy[k]});
            end
            @(negedge clk);
        end
        ser_ready = 1'b1;
        #1;
        checks++;
        if ({ser_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_idle got vld/rdy=%b exp=01", {ser_valid, in_ready});
        end
    endtask

    task automatic test_len_edge();
        logic [2:0] lens [2];
        logic [3:0] exp_bits;
        lens[0]  = 3'd0;
        lens[1]  = 3'd7;
        exp_bits = 4'b1000;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 4'b1000; in_len = lens[t]; ser_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if ({ser_valid, ser_bit, ser_last} !== {1'b1, exp_bits[i], 1'(i == 3)}) begin
                    failures++;
                    $display("FAIL len%0d_bit%0d got vld/bit/last=%b exp=%b", lens[t], i,
                             {ser_valid, ser_bit, ser_last}, {1'b1, exp_bits[i], 1'(i == 3)});
                end
                @(negedge clk);
            end
            #1;
            checks++;
            if (ser_valid !== 1'b0) begin
                failures++;
                $display("FAIL len%0d_end got vld=%b exp=0", lens[t], ser_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_new;
        exp_new = 2'b10;
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b1011; in_len = 3'd4; ser_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({ser_valid, ser_bit} !== 2'b11) begin
                failures++;
                $display("FAIL rmid_bit%0d got vld/bit=%b exp=11", i, {ser_valid, ser_bit});
            end
            @(negedge clk);
        end
        areset_n = 1'b0;
        #1;
        checks++;
        if ({ser_valid, in_ready, sr_areset, sr_load, sr_ena} !== 5'b00100) begin
            failures++;
            $display("FAIL rmid_in_reset got vld/rdy/arst/load/ena=%b exp=00100",
                     {ser_valid, in_ready, sr_areset, sr_load, sr_ena});
        end
        @(negedge clk);
        areset_n = 1'b1;
        #1;
        checks++;
        if ({ser_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rmid_after_reset got vld/rdy=%b exp=01", {ser_valid, in_ready});
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0110; in_len = 3'd2;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({ser_valid, ser_bit, ser_last} !== {1'b1, exp_new[i], 1'(i == 1)}) begin
                failures++;
                $display("FAIL rmid_new_bit%0d got vld/bit/last=%b exp=%b", i,
                         {ser_valid, ser_bit, ser_last}, {1'b1, exp_new[i], 1'(i == 1)});
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({ser_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rmid_new_idle got vld/rdy=%b exp=01", {ser_valid, in_ready});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish by t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset_n  = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        in_len    = 3'd0;
        ser_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_len_edge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
